fp_compare_pipe: RTL and testbench

//  Streaming, parametrised comparator for FloPoCo-format floats ({exc[1:0],sign,exp[WE-1:0],frac[WF-1:0]}).

---
 rtl/fp_cmp_pkg.sv | 25 ++
 rtl/fp_cmp_core.sv | 71 +++++++
 rtl/fp_compare_pipe.sv | 131 +++++++++++++
 tb/tb_fp_compare_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared op codes, exception codes and width helper for the FloPoCo float comparator.
package fp_cmp_pkg;

  typedef enum logic [2:0] {
    OP_LT = 3'd0,
    OP_LE = 3'd1,
    OP_GT = 3'd2,
    OP_GE = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    EXC_ZERO = 2'b00,
    EXC_NORM = 2'b01,
    EXC_INF  = 2'b10,
    EXC_NAN  = 2'b11
  } exc_e;

  // Operand width of a FloPoCo float: {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
  function automatic int fpw(input int we, input int wf);
    return wf + we + 3;
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational classification and subtractor-free compare of two FloPoCo floats.
// Optional min/max selection when FPC_MINMAX_EN is defined.
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 10
) (
  input  logic [fpw(WE, WF)-1:0] a,
  input  logic [fpw(WE, WF)-1:0] b,
  output logic                   lt,
  output logic                   eq,
  output logic                   unord
`ifdef FPC_MINMAX_EN
  ,
  output logic [fpw(WE, WF)-1:0] min_val,
  output logic [fpw(WE, WF)-1:0] max_val
`endif
);

  localparam int W  = fpw(WE, WF);
  localparam int KW = WE + WF + 2;

  // Zero and infinity carry no meaningful exp/frac, so they collapse to one key each.
  function automatic logic [KW-1:0] mag_key(input logic [W-1:0] x);
    logic [1:0] exc;
    exc = x[W-1 -: 2];
    if (exc == EXC_ZERO || exc == EXC_INF) return {exc, {(WE + WF){1'b0}}};
    return {exc, x[WE+WF-1:0]};
  endfunction

  logic [KW-1:0] key_a, key_b;
  logic          sign_a, sign_b;
  logic          both_zero;

  assign key_a     = mag_key(a);
  assign key_b     = mag_key(b);
  assign sign_a    = a[W-3];
  assign sign_b    = b[W-3];
  assign unord     = (a[W-1 -: 2] == EXC_NAN) || (b[W-1 -: 2] == EXC_NAN);
  assign both_zero = (key_a == '0) && (key_b == '0);
  assign eq        = both_zero || ((key_a == key_b) && (sign_a == sign_b));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    lt = 1'b0;
    if (!both_zero) begin
      if (sign_a != sign_b) lt = sign_a;
      else if (sign_a)      lt = key_b < key_a;
      else                  lt = key_a < key_b;
    end
  end

`ifdef FPC_MINMAX_EN
  always_comb begin
    min_val = a;
    max_val = a;
    if (unord) begin
      min_val = {EXC_NAN, {(W - 2){1'b0}}};
      max_val = {EXC_NAN, {(W - 2){1'b0}}};
    end else if (both_zero && (sign_a != sign_b)) begin
      min_val = {EXC_ZERO, 1'b1, {(W - 3){1'b0}}};
      max_val = '0;
    end else if (!eq) begin
      min_val = lt ? a : b;
      max_val = lt ? b : a;
    end
  end
`endif

endmodule

// File: rtl/fp_compare_pipe.sv
// Elastic valid/ready pipeline around fp_cmp_core: compare in stage 0, STAGES deep, tag sideband.
// Define FPC_MINMAX_EN to add out_min/out_max carried alongside the result.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int WE     = 11,
  parameter int WF     = 10,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [fpw(WE, WF)-1:0] in_a,
  input  logic [fpw(WE, WF)-1:0] in_b,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_res,
  output logic                   out_unord,
  output logic [TAG_W-1:0]       out_tag
`ifdef FPC_MINMAX_EN
  ,
  output logic [fpw(WE, WF)-1:0] out_min,
  output logic [fpw(WE, WF)-1:0] out_max
`endif
);

  localparam int W = fpw(WE, WF);

  typedef struct packed {
    logic             res;
    logic             unord;
    logic [TAG_W-1:0] tag;
`ifdef FPC_MINMAX_EN
    logic [W-1:0]     mn;
    logic [W-1:0]     mx;
`endif
  } stage_t;

  logic lt, eq, unord;
`ifdef FPC_MINMAX_EN
  logic [W-1:0] min_val, max_val;
`endif

  fp_cmp_core #(.WE(WE), .WF(WF)) u_core (
    .a       (in_a),
    .b       (in_b),
    .lt      (lt),
    .eq      (eq),
    .unord   (unord)
`ifdef FPC_MINMAX_EN
    ,
    .min_val (min_val),
    .max_val (max_val)
`endif
  );

  logic res;

  always_comb begin
    res = 1'b0;
    case (in_op)
      OP_LT:   res = lt;
      OP_LE:   res = lt | eq;
      OP_GT:   res = ~lt & ~eq;
      OP_GE:   res = ~lt;
      OP_EQ:   res = eq;
      OP_NE:   res = ~eq;
      default: res = 1'b0;
    endcase
    if (unord) res = (in_op == OP_NE);
  end

  stage_t stage_in;

  always_comb begin
    stage_in       = '0;
    stage_in.res   = res;
    stage_in.unord = unord;
    stage_in.tag   = in_tag;
`ifdef FPC_MINMAX_EN
    stage_in.mn    = min_val;
    stage_in.mx    = max_val;
`endif
  end

  logic [STAGES-1:0] valid_q;
  stage_t            data_q [STAGES];
  logic [STAGES:0]   adv;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) adv[k] = ~valid_q[k] | adv[k+1];
  end

  assign in_ready = adv[0];

  // NOTE: the data registers are reset as well because the outputs must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage sees pre-edge values.
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= stage_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_res   = data_q[STAGES-1].res;
  assign out_unord = data_q[STAGES-1].unord;
  assign out_tag   = data_q[STAGES-1].tag;
`ifdef FPC_MINMAX_EN
  assign out_min   = data_q[STAGES-1].mn;
  assign out_max   = data_q[STAGES-1].mx;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: number-line model, scoreboard and directed vectors.
module tb_fp_compare_pipe;
  import fp_cmp_pkg::*;

  localparam int WE = 11, WF = 10, STAGES = 2, TAG_W = 8;
  localparam int W  = fpw(WE, WF);

  localparam logic [W-1:0] P1 = 24'h4FFC00, P2 = 24'h500000, N1 = 24'h6FFC00;
  localparam logic [W-1:0] PZ = 24'h000000, NZ = 24'h200000, PINF = 24'h800000, QNAN = 24'hC00000;
  localparam logic [TAG_W-1:0] LAT_TAG = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a, in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_res, out_unord;
  logic [TAG_W-1:0] out_tag;
`ifdef FPC_MINMAX_EN
  logic [W-1:0]     out_min, out_max;
`endif

  fp_compare_pipe #(.WE(WE), .WF(WF), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_unord (out_unord),
    .out_tag   (out_tag)
`ifdef FPC_MINMAX_EN
    ,
    .out_min   (out_min),
    .out_max   (out_max)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    logic             res;
    logic             unord;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     mn;
    logic [W-1:0]     mx;
    int               cyc;
  } exp_t;

  // Place a float on a signed integer number line: zero at 0, infinities beyond every normal.
  function automatic longint num_val(input logic [W-1:0] x);
    longint m;
    case (x[W-1 -: 2])
      2'b00:   m = 0;
      2'b01:   m = longint'(x[WE+WF-1:0]) + 1;
      default: m = longint'(1) << 40;
    endcase
    return x[W-3] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint va, vb;
    va      = num_val(a);
    vb      = num_val(b);
    e.tag   = tag;
    e.cyc   = 0;
    e.unord = (a[W-1 -: 2] == 2'b11) || (b[W-1 -: 2] == 2'b11);
    case (op)
      3'd0:    e.res = va <  vb;
      3'd1:    e.res = va <= vb;
      3'd2:    e.res = va >  vb;
      3'd3:    e.res = va >= vb;
      3'd4:    e.res = va == vb;
      3'd5:    e.res = va != vb;
      default: e.res = 1'b0;
    endcase
    if (e.unord) e.res = (op == 3'd5);
    if (e.unord) begin
      e.mn = QNAN;
      e.mx = QNAN;
    end else if (va == vb && va == 0 && a[W-3] != b[W-3]) begin
      e.mn = NZ;
      e.mx = PZ;
    end else if (va == vb) begin
      e.mn = a;
      e.mx = a;
    end else begin
      e.mn = (va < vb) ? a : b;
      e.mx = (va < vb) ? b : a;
    end
    return e;
  endfunction

  function automatic logic [63:0] out_vec();
`ifdef FPC_MINMAX_EN
    return {out_res, out_unord, out_tag, out_min, out_max};
`else
    return {out_res, out_unord, out_tag};
`endif
  endfunction

  exp_t        q[$];
  exp_t        e_pop, e_push;
  logic        held_v = 1'b0;
  logic [63:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: stall stability, in-order scoreboard and model push.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid_hold", out_valid, 1'b1);
        check("stall_data_hold", out_vec(), held);
      end
      held_v = out_valid && !out_ready;
      held   = out_vec();
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e_pop = q.pop_front();
          n_out++;
          check("res", out_res, e_pop.res);
          check("unord", out_unord, e_pop.unord);
          check("tag", out_tag, e_pop.tag);
`ifdef FPC_MINMAX_EN
          check("min", out_min, e_pop.mn);
          check("max", out_max, e_pop.mx);
`endif
          if (e_pop.tag == LAT_TAG) check("latency", cyc - e_pop.cyc, STAGES);
        end
      end
      if (in_valid && in_ready) begin
        e_push     = model(in_a, in_b, in_op, in_tag);
        e_push.cyc = cyc;
        q.push_back(e_push);
      end
    end
  end

  logic rand_ready  = 1'b0;
  logic fixed_ready = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Present one pair and return just after the edge that accepted it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    do begin
      @(negedge clk);
      budget++;
    end while (!in_ready && budget < 200);
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         res;
    logic         unord;
  } vec_t;

  vec_t         dir [13];
  logic [W-1:0] pool [7];
  exp_t         pin;
  int           base, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;

    dir[0]  = '{N1,   P1,   3'd0, 1'b1, 1'b0};
    dir[1]  = '{N1,   P1,   3'd3, 1'b0, 1'b0};
    dir[2]  = '{PZ,   NZ,   3'd4, 1'b1, 1'b0};
    dir[3]  = '{PZ,   NZ,   3'd0, 1'b0, 1'b0};
    dir[4]  = '{QNAN, PINF, 3'd0, 1'b0, 1'b1};
    dir[5]  = '{QNAN, PINF, 3'd4, 1'b0, 1'b1};
    dir[6]  = '{QNAN, PINF, 3'd5, 1'b1, 1'b1};
    dir[7]  = '{P1,   P2,   3'd6, 1'b0, 1'b0};
    dir[8]  = '{PINF, QNAN, 3'd7, 1'b0, 1'b1};
    dir[9]  = '{P2,   N1,   3'd2, 1'b1, 1'b0};
    dir[10] = '{PINF, P2,   3'd3, 1'b1, 1'b0};
    dir[11] = '{NZ,   P1,   3'd1, 1'b1, 1'b0};
    dir[12] = '{P1,   P1,   3'd5, 1'b0, 1'b0};
    pool    = '{P1, P2, N1, PZ, NZ, PINF, QNAN};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_res", out_res, 1'b0);
    check("reset_out_unord", out_unord, 1'b0);
    check("reset_out_tag", out_tag, '0);
`ifdef FPC_MINMAX_EN
    check("reset_out_min", out_min, '0);
    check("reset_out_max", out_max, '0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Latency: 2.0 > 1.0 through an empty pipe with out_ready held high.
    pin = model(P2, P1, 3'd2, LAT_TAG);
    check("pin_gt_res", pin.res, 1'b1);
    check("pin_gt_unord", pin.unord, 1'b0);
    send(P2, P1, 3'd2, LAT_TAG);
    idle();
    drain(50);

`ifdef FPC_MINMAX_EN
    pin = model(P2, N1, 3'd0, 8'h00);
    check("pin_min_2_m1", pin.mn, 24'h6FFC00);
    check("pin_max_2_m1", pin.mx, 24'h500000);
    pin = model(PZ, NZ, 3'd0, 8'h00);
    check("pin_min_zeros", pin.mn, 24'h200000);
    check("pin_max_zeros", pin.mx, 24'h000000);
`endif

    // Directed vectors: pin the model to the literal table, then run them back-to-back.
    for (int i = 0; i < 13; i++) begin
      pin = model(dir[i].a, dir[i].b, dir[i].op, 8'h00);
      check($sformatf("pin_res_%0d", i), pin.res, dir[i].res);
      check($sformatf("pin_unord_%0d", i), pin.unord, dir[i].unord);
    end
    for (int i = 0; i < 13; i++) send(dir[i].a, dir[i].b, dir[i].op, 8'(8'h20 + i));
    idle();
    drain(100);

    // 16 tagged pairs with random backpressure.
    base       = n_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(pool[i % 7], pool[(i * 3 + 1) % 7], 3'(i % 6), 8'(i));
    idle();
    drain(500);
    check("b2b_count", n_out - base, 16);
    rand_ready  = 1'b0;
    fixed_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with two transactions held in the stalled pipe.
    fixed_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(P2, P1, 3'd2, 8'h77);
    send(QNAN, P1, 3'd0, 8'h78);
    idle();
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_res", out_res, 1'b0);
    check("midrst_out_unord", out_unord, 1'b0);
    check("midrst_out_tag", out_tag, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    fixed_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", seen, 0);

    @(posedge clk);
    #1;
    send(N1, P1, 3'd1, 8'h55);
    idle();
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
